// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/issue bus of the register file scoreboard
interface regfile_scoreboard_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] reg1addr;
  logic [ADDR_W-1:0] reg2addr;
  logic [ADDR_W-1:0] regWaddr;
  logic [WIDTH-1:0]  data;
  logic              regWflag;
  logic              issue_flag;
  logic [ADDR_W-1:0] issue_addr;
  logic [WIDTH-1:0]  reg1content;
  logic [WIDTH-1:0]  reg2content;
  logic              reg1busy;
  logic              reg2busy;
  logic [ADDR_W:0]   pendcount;

  modport master (
    output reg1addr, reg2addr, regWaddr, data, regWflag, issue_flag, issue_addr,
    input  reg1content, reg2content, reg1busy, reg2busy, pendcount
  );

  modport slave (
    input  reg1addr, reg2addr, regWaddr, data, regWflag, issue_flag, issue_addr,
    output reg1content, reg2content, reg1busy, reg2busy, pendcount
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/1W register file with per-register pending scoreboard
// Reads are combinational with optional write forwarding; pendcount tracks popcount of pending bits.
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  pendcount_q, pendcount_d;

  logic wr_en, iss_en, cnt_inc, cnt_dec;
  logic [WIDTH-1:0] rd1, rd2;
  logic bsy1, bsy2;

  // Register 0 silently absorbs writes and issues when hard-wired to zero.
  assign wr_en  = bus.regWflag   && !(ZERO_REG != 0 && bus.regWaddr   == '0);
  assign iss_en = bus.issue_flag && !(ZERO_REG != 0 && bus.issue_addr == '0);

  always_comb begin
    pend_d = pend_q;
    if (wr_en)  pend_d[bus.regWaddr]   = 1'b0;
    if (iss_en) pend_d[bus.issue_addr] = 1'b1;
  end

  // A same-address issue keeps the bit set, so the write's clear is cancelled.
  assign cnt_inc = iss_en && !pend_q[bus.issue_addr];
  assign cnt_dec = wr_en && pend_q[bus.regWaddr] &&
                   !(iss_en && bus.issue_addr == bus.regWaddr);

  always_comb begin
    pendcount_d = pendcount_q;
    if (cnt_inc && !cnt_dec)      pendcount_d = pendcount_q + CNT_ONE;
    else if (cnt_dec && !cnt_inc) pendcount_d = pendcount_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q      <= '0;
      pendcount_q <= '0;
    end else begin
      if (wr_en) regs_q[bus.regWaddr] <= bus.data;
      pend_q      <= pend_d;
      pendcount_q <= pendcount_d;
    end
  end

  always_comb begin
    rd1  = regs_q[bus.reg1addr];
    bsy1 = pend_q[bus.reg1addr];
    if (BYPASS != 0 && bus.regWflag && bus.regWaddr == bus.reg1addr) begin
      rd1  = bus.data;
      bsy1 = 1'b0;
    end
    if (ZERO_REG != 0 && bus.reg1addr == '0) begin
      rd1  = '0;
      bsy1 = 1'b0;
    end
  end

  always_comb begin
    rd2  = regs_q[bus.reg2addr];
    bsy2 = pend_q[bus.reg2addr];
    if (BYPASS != 0 && bus.regWflag && bus.regWaddr == bus.reg2addr) begin
      rd2  = bus.data;
      bsy2 = 1'b0;
    end
    if (ZERO_REG != 0 && bus.reg2addr == '0) begin
      rd2  = '0;
      bsy2 = 1'b0;
    end
  end

  assign bus.reg1content = rd1;
  assign bus.reg2content = rd2;
  assign bus.reg1busy    = bsy1;
  assign bus.reg2busy    = bsy2;
  assign bus.pendcount   = pendcount_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard, bypass and non-bypass builds
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic [4:0]  r1a, r2a, wa, ia;
  logic [31:0] wd;
  logic        we, ie;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(5)) a_if ();
  regfile_scoreboard_if #(.WIDTH(32), .ADDR_W(5)) b_if ();

  assign a_if.reg1addr = r1a;  assign b_if.reg1addr = r1a;
  assign a_if.reg2addr = r2a;  assign b_if.reg2addr = r2a;
  assign a_if.regWaddr = wa;   assign b_if.regWaddr = wa;
  assign a_if.data = wd;       assign b_if.data = wd;
  assign a_if.regWflag = we;   assign b_if.regWflag = we;
  assign a_if.issue_flag = ie; assign b_if.issue_flag = ie;
  assign a_if.issue_addr = ia; assign b_if.issue_addr = ia;

  regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave));
  regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; ie = 1'b0; wa = '0; ia = '0; wd = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); r1a = '0; r2a = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      r1a = 5'(i); r2a = 5'(31 - i);
      #1;
      n_checks++;
      if (a_if.reg1content !== 32'h0 || a_if.reg2content !== 32'h0 ||
          b_if.reg1content !== 32'h0 || b_if.reg2content !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_content addr %0d got a=%h/%h b=%h/%h want 0", i,
                 a_if.reg1content, a_if.reg2content, b_if.reg1content, b_if.reg2content);
      end
      n_checks++;
      if ({a_if.reg1busy, a_if.reg2busy, b_if.reg1busy, b_if.reg2busy} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_busy addr %0d got %b%b%b%b want 0000", i,
                 a_if.reg1busy, a_if.reg2busy, b_if.reg1busy, b_if.reg2busy);
      end
    end
    n_checks++;
    if (a_if.pendcount !== 6'd0 || b_if.pendcount !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_pendcount got %0d/%0d want 0", a_if.pendcount, b_if.pendcount);
    end
    rst = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'hDEADBEEF;
    step();
    rst = 1'b0; idle(); r1a = 5'd9;
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h0 || b_if.reg1content !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_overrides_write got %h/%h want 0", a_if.reg1content, b_if.reg1content);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 5'd9; wd = 32'h0000000C; r1a = 5'd9;
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h0000000C) begin
      n_fail++;
      $display("FAIL bypass_same_cycle got %h want 0000000c", a_if.reg1content);
    end
    n_checks++;
    if (b_if.reg1content !== 32'h0) begin
      n_fail++;
      $display("FAIL nobypass_same_cycle got %h want 00000000", b_if.reg1content);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h0000000C || b_if.reg1content !== 32'h0000000C) begin
      n_fail++;
      $display("FAIL write_after_edge got %h/%h want 0000000c", a_if.reg1content, b_if.reg1content);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; r1a = 5'd0;
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_bypass got %h want 0", a_if.reg1content);
    end
    step();
    idle(); ie = 1'b1; ia = 5'd0;
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h0 || b_if.reg1content !== 32'h0) begin
      n_fail++;
      $display("FAIL zero_stored got %h/%h want 0", a_if.reg1content, b_if.reg1content);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (a_if.reg1busy !== 1'b0 || a_if.pendcount !== 6'd0 || b_if.pendcount !== 6'd0) begin
      n_fail++;
      $display("FAIL zero_issue got busy=%b cnt=%0d/%0d want 0 0/0", a_if.reg1busy,
               a_if.pendcount, b_if.pendcount);
    end
  endtask

  task automatic test_issue();
    ie = 1'b1; ia = 5'd5; r2a = 5'd5;
    step();
    n_checks++;
    if (a_if.pendcount !== 6'd1) begin
      n_fail++;
      $display("FAIL issue_cnt1 got %0d want 1", a_if.pendcount);
    end
    ia = 5'd7;
    step();
    idle();
    #1;
    n_checks++;
    if (a_if.pendcount !== 6'd2 || b_if.pendcount !== 6'd2) begin
      n_fail++;
      $display("FAIL issue_cnt2 got %0d/%0d want 2", a_if.pendcount, b_if.pendcount);
    end
    n_checks++;
    if (a_if.reg2busy !== 1'b1 || b_if.reg2busy !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_busy5 got %b/%b want 1", a_if.reg2busy, b_if.reg2busy);
    end
    we = 1'b1; wa = 5'd5; wd = 32'h55;
    #1;
    n_checks++;
    if (a_if.reg2busy !== 1'b0 || b_if.reg2busy !== 1'b1) begin
      n_fail++;
      $display("FAIL write_clear_bypass got %b/%b want 0/1", a_if.reg2busy, b_if.reg2busy);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (a_if.pendcount !== 6'd1 || b_if.pendcount !== 6'd1 || b_if.reg2busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_clear_edge got cnt=%0d/%0d busy=%b want 1/1 0",
               a_if.pendcount, b_if.pendcount, b_if.reg2busy);
    end
  endtask

  task automatic test_same_cycle();
    // pending: r7
    we = 1'b1; wa = 5'd3; wd = 32'h11; ie = 1'b1; ia = 5'd3; r1a = 5'd3;
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h11 || a_if.reg1busy !== 1'b0) begin
      n_fail++;
      $display("FAIL same_addr_bypass got %h busy=%b want 00000011 0", a_if.reg1content, a_if.reg1busy);
    end
    step();
    idle();
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'h11 || a_if.reg1busy !== 1'b1 || a_if.pendcount !== 6'd2) begin
      n_fail++;
      $display("FAIL same_addr_edge got %h busy=%b cnt=%0d want 00000011 1 2",
               a_if.reg1content, a_if.reg1busy, a_if.pendcount);
    end
    ie = 1'b1; ia = 5'd6;
    step();
    n_checks++;
    if (a_if.pendcount !== 6'd3) begin
      n_fail++;
      $display("FAIL issue_r6 got %0d want 3", a_if.pendcount);
    end
    ia = 5'd4; we = 1'b1; wa = 5'd6; wd = 32'h66;
    step();
    idle(); r1a = 5'd4; r2a = 5'd6;
    #1;
    n_checks++;
    if (a_if.pendcount !== 6'd3 || b_if.pendcount !== 6'd3) begin
      n_fail++;
      $display("FAIL opposite_cnt got %0d/%0d want 3", a_if.pendcount, b_if.pendcount);
    end
    n_checks++;
    if (a_if.reg1busy !== 1'b1 || a_if.reg2busy !== 1'b0 || a_if.reg2content !== 32'h66) begin
      n_fail++;
      $display("FAIL opposite_state got b4=%b b6=%b r6=%h want 1 0 00000066",
               a_if.reg1busy, a_if.reg2busy, a_if.reg2content);
    end
  endtask

  task automatic test_back_to_back();
    // pending: r3 r4 r7
    ie = 1'b1; ia = 5'd4;
    step();
    n_checks++;
    if (a_if.pendcount !== 6'd3) begin
      n_fail++;
      $display("FAIL reissue_cnt got %0d want 3", a_if.pendcount);
    end
    idle(); we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
    step();
    n_checks++;
    if (a_if.pendcount !== 6'd3) begin
      n_fail++;
      $display("FAIL write_nonpending_cnt got %0d want 3", a_if.pendcount);
    end
    idle(); r1a = 5'd9; r2a = 5'd9;
    #1;
    n_checks++;
    if (a_if.reg1content !== 32'hA5A5A5A5 || a_if.reg2content !== 32'hA5A5A5A5 ||
        b_if.reg2content !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL dual_port_same got %h/%h/%h want a5a5a5a5", a_if.reg1content,
               a_if.reg2content, b_if.reg2content);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; we = 1'b1; wa = 5'd12; wd = 32'h1234; ie = 1'b1; ia = 5'd13;
    step();
    rst = 1'b0; idle();
    #1;
    n_checks++;
    if (a_if.pendcount !== 6'd0 || b_if.pendcount !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_reset_cnt got %0d/%0d want 0", a_if.pendcount, b_if.pendcount);
    end
    for (int i = 0; i < 32; i++) begin
      r1a = 5'(i); r2a = 5'(i);
      #1;
      n_checks++;
      if (a_if.reg1content !== 32'h0 || b_if.reg2content !== 32'h0 ||
          a_if.reg1busy !== 1'b0 || b_if.reg2busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_reg addr %0d got %h/%h busy %b/%b want 0", i,
                 a_if.reg1content, b_if.reg2content, a_if.reg1busy, b_if.reg2busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero_reg();
    test_issue();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the single-cycle register file, for the pipelined MIPS datapath. It has two combinational read ports and one clocked write port, with optional write-to-read bypass and an optional hard-wired zero register. A per-register pending scoreboard flags destinations of in-flight instructions so hazard logic can stall dependent reads.

Parameters:
WIDTH, 32, data width of each register in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, is never pending
BYPASS, 1, 1 = same-cycle write data and pending-clear are forwarded to the read ports

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
reg1addr  input  ADDR_W  read port 1 address
reg2addr  input  ADDR_W  read port 2 address
regWaddr  input  ADDR_W  write address
data  input  WIDTH  write data
regWflag  input  1  write enable; also clears the pending bit of regWaddr
issue_flag  input  1  marks issue_addr pending (instruction issued with this destination)
issue_addr  input  ADDR_W  destination register being issued
reg1content  output  WIDTH  read port 1 data
reg2content  output  WIDTH  read port 2 data
reg1busy  output  1  pending bit for reg1addr
reg2busy  output  1  pending bit for reg2addr
pendcount  output  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset: on a rising edge with rst=1, all DEPTH registers <= 0, all pending bits <= 0, pendcount <= 0. rst overrides every concurrent write or issue. After reset, every read returns 0 and every busy output is 0.
- Write: at a rising edge with regWflag=1 and rst=0, reg[regWaddr] <= data and pending[regWaddr] <= 0. When ZERO_REG=1 and regWaddr=0, the write is dropped.
- Issue: at a rising edge with issue_flag=1 and rst=0, pending[issue_addr] <= 1. When ZERO_REG=1 and issue_addr=0, the issue is ignored.
- Write and issue to the same address in the same cycle: data is stored and the pending bit ends at 1 (issue wins). Write and issue to different addresses: both take effect.
- Read (combinational, zero latency): regNcontent = reg[regNaddr].
  - BYPASS=1 and regWflag=1 and regWaddr==regNaddr (and the address is not the zero register): regNcontent = data.
  - ZERO_REG=1 and regNaddr=0: regNcontent = 0, regardless of bypass.
- Busy (combinational): regNbusy = pending[regNaddr].
  - BYPASS=1 and regWflag=1 and regWaddr==regNaddr: regNbusy = 0, even if an issue to the same address occurs this cycle (that issue becomes visible next cycle).
  - ZERO_REG=1 and address 0: regNbusy = 0.
  - BYPASS=0: busy and content reflect only stored state; the write becomes visible the cycle after the edge.
- pendcount: registered and always equal to the popcount of the pending bits. Per edge it changes by +1, 0, or -1:
  - +1 when an issue sets a previously clear bit;
  - -1 when a write clears a set bit with no same-address issue;
  - 0 when issue and write hit different addresses and each changes one bit in opposite directions.
  - Re-issuing an already-pending register or writing a non-pending one: no count change.
  - Maximum value is DEPTH-1 with ZERO_REG=1, DEPTH otherwise; no wrap.
- Both read ports may address the same register; the outputs are then identical.
- Out-of-range addresses are impossible (DEPTH = 2**ADDR_W).

Test Plan:
- Reset, then read all addresses -> every content 0, every busy 0, pendcount 0; then write 0xDEADBEEF to r9 with rst=1 in the same cycle -> r9 still reads 0.
- Write 0x0000000C to r9, reg1addr=9 in the same cycle -> reg1content=0x0000000C combinationally with BYPASS=1; with BYPASS=0 -> 0 until after the edge, then 0x0000000C.
- Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> reg1content for address 0 stays 0; issue to r0 -> reg1busy stays 0 and pendcount stays 0.
- Issue r5, then issue r7 -> pendcount 1 then 2 and reg2busy(5)=1; write r5 -> reg2busy=0 in the write cycle (bypass), pendcount 1 after the edge.
- Same cycle: write r3=0x11 and issue r3 -> r3 reads 0x11, busy=1 next cycle, pendcount +1; same cycle: issue r4 and write pending r6 -> pendcount unchanged.
- Assert rst mid-sequence with 3 registers pending -> next cycle pendcount=0, all busy 0, all contents 0.
